// File: rtl/hex_bcd_pkg.sv
// Shared constants, state type and BCD helper for the hex/BCD display controller.
package hex_bcd_pkg;

    localparam logic [1:0] AddrValue    = 2'd0;
    localparam logic [1:0] AddrCtrl     = 2'd1;
    localparam logic [1:0] AddrStatus   = 2'd2;
    localparam logic [1:0] AddrBlinkDiv = 2'd3;

    localparam int unsigned CtrlEnable = 0;
    localparam int unsigned CtrlMode   = 1;
    localparam int unsigned CtrlBlink  = 2;
    localparam int unsigned CtrlLzb    = 3;

    localparam logic [6:0]  SegBlank = 7'h7F;
    localparam logic [6:0]  SegDash  = 7'h3F;
    localparam logic [15:0] DecMax   = 16'd9999;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch
    } state_e;

    // Double-dabble correction applied before each shift step.
    function automatic logic [19:0] bcd_adjust(input logic [19:0] bcd);
        logic [19:0] b;
        b = bcd;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                b[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/hex_bcd_display_if.sv
// Avalon-MM slave bus bundle for the hex/BCD display controller.
interface hex_bcd_display_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment glyph (bit0=a .. bit6=g).
module hex_seg_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end
endmodule

// File: rtl/hex_bcd_display.sv
// Four-digit hex/decimal 7-segment display controller with Avalon-MM registers.
// Optional blink divider is built only when HEX_BCD_BLINK_EN is defined.
module hex_bcd_display
    import hex_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    hex_bcd_display_if.slave bus,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3
);
    logic        w_wr, w_start, w_busy, w_latch, w_blink_off;
    logic [23:0] w_blink_div;
    logic [3:0]  w_ctrl_mask;
    state_e      r_state, w_state_next;
    logic [3:0]  r_cnt;
    logic [15:0] r_value, r_bin;
    logic [3:0]  r_ctrl;
    logic [19:0] r_bcd, w_bcd_adj;
    logic [15:0] r_nib, w_nib;
    logic [3:0]  r_blank, w_blank, w_dz;
    logic        r_dash, w_dash, r_ovf, w_ovf;
    logic [6:0]  w_seg [4];
    logic [6:0]  w_hex [4];

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_start = w_wr & ((bus.address == AddrValue) | (bus.address == AddrCtrl));
    assign w_busy  = (r_state != StIdle);
    // A restart landing on the LATCH cycle wins; the stale result is dropped.
    assign w_latch = (r_state == StLatch) & ~w_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= '0;
            r_ctrl  <= '0;
        end else if (w_wr) begin
            if (bus.address == AddrValue) r_value <= bus.writedata[15:0];
            if (bus.address == AddrCtrl)  r_ctrl  <= bus.writedata[3:0] & w_ctrl_mask;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_start) w_state_next = StShift;
            StShift: begin
                if (w_start)             w_state_next = StShift;
                else if (r_cnt == 4'd15) w_state_next = StLatch;
            end
            StLatch: w_state_next = w_start ? StShift : StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_bcd_adj = bcd_adjust(r_bcd);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_bin <= '0;
            r_bcd <= '0;
        end else if (w_start) begin
            r_cnt <= '0;
            r_bin <= (bus.address == AddrValue) ? bus.writedata[15:0] : r_value;
            r_bcd <= '0;
        end else if (r_state == StShift) begin
            r_cnt <= r_cnt + 4'd1;
            r_bin <= {r_bin[14:0], 1'b0};
            r_bcd <= {w_bcd_adj[18:0], r_bin[15]};
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) w_dz[i] = (r_bcd[4*i +: 4] == 4'd0);
        w_nib   = r_value;
        w_blank = '0;
        w_dash  = 1'b0;
        w_ovf   = 1'b0;
        if (r_ctrl[CtrlMode]) begin
            w_nib = r_bcd[15:0];
            if (r_value > DecMax) begin
                w_ovf  = 1'b1;
                w_dash = 1'b1;
            end else if (r_ctrl[CtrlLzb]) begin
                w_blank = {w_dz[3], &w_dz[3:2], &w_dz[3:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nib   <= '0;
            r_blank <= 4'hF;
            r_dash  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_latch) begin
            r_nib   <= w_nib;
            r_blank <= w_blank;
            r_dash  <= w_dash;
            r_ovf   <= w_ovf;
        end
    end

`ifdef HEX_BCD_BLINK_EN
    logic [23:0] r_blink_div, r_blink_cnt;
    logic        r_phase;
    logic        w_unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_div <= '0;
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_wr && (bus.address == AddrBlinkDiv)) begin
            r_blink_div <= bus.writedata[23:0];
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_div == 24'd0) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == r_blink_div - 24'd1) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 24'd1;
        end
    end

    assign w_blink_off    = r_ctrl[CtrlBlink] & r_phase;
    assign w_blink_div    = r_blink_div;
    assign w_ctrl_mask    = 4'hF;
    assign w_unused_wdata = ^{bus.writedata[31:24], w_bcd_adj[19]};
`else
    logic w_unused_wdata;

    assign w_blink_off    = 1'b0;
    assign w_blink_div    = '0;
    assign w_ctrl_mask    = 4'b1011;
    assign w_unused_wdata = ^{bus.writedata[31:16], w_bcd_adj[19]};
`endif

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                AddrValue:  bus.readdata = {16'h0, r_value};
                AddrCtrl:   bus.readdata = {28'h0, r_ctrl};
                AddrStatus: bus.readdata = {30'h0, r_ovf, w_busy};
                default:    bus.readdata = {8'h0, w_blink_div};
            endcase
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        hex_seg_decode u_dec (
            .i_nibble (r_nib[4*gi +: 4]),
            .o_seg    (w_seg[gi])
        );
        assign w_hex[gi] = (!r_ctrl[CtrlEnable] || w_blink_off || r_blank[gi]) ? SegBlank :
                           (r_dash ? SegDash : w_seg[gi]);
    end

    assign hex0 = w_hex[0];
    assign hex1 = w_hex[1];
    assign hex2 = w_hex[2];
    assign hex3 = w_hex[3];
endmodule

// File: tb/tb_hex_bcd_display.sv
// Scoreboard bench for hex_bcd_display: randomized register traffic against a display model.
module tb_hex_bcd_display;
    import hex_bcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] hex0, hex1, hex2, hex3;

    hex_bcd_display_if bus_if ();

    hex_bcd_display dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .hex0    (hex0),
        .hex1    (hex1),
        .hex2    (hex2),
        .hex3    (hex3)
    );

    always #5 clk = ~clk;

`ifdef HEX_BCD_BLINK_EN
    localparam bit BlinkEn = 1'b1;
`else
    localparam bit BlinkEn = 1'b0;
`endif
    localparam logic [27:0] AllBlank = {4{7'h7F}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected responses tagged with the cycle they are due.
    int          q_cyc [$];
    bit          q_hex [$];
    logic [31:0] q_exp [$];
    string       q_name[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [15:0] m_value;
    logic [3:0]  m_ctrl;
    int          m_bdiv, m_bcyc, m_start, m_sw;
    logic [27:0] m_old, m_new;
    bit          m_oovf, m_novf;

    function automatic logic [27:0] disp_of(input logic [15:0] v, input logic [3:0] c);
        logic [27:0] r;
        int          d[4];
        int          n;
        bit          lead;
        r = AllBlank;
        if (!c[1]) begin
            for (int i = 0; i < 4; i++) r[7*i +: 7] = glyph[int'((v >> (4*i)) & 16'hF)];
        end else if (v > 16'd9999) begin
            r = {4{7'h3F}};
        end else begin
            n = int'(v);
            for (int i = 0; i < 4; i++) begin
                d[i] = n % 10;
                n    = n / 10;
            end
            lead = c[3];
            for (int i = 3; i >= 0; i--) begin
                if (lead && i > 0 && d[i] == 0) r[7*i +: 7] = 7'h7F;
                else begin
                    lead = 1'b0;
                    r[7*i +: 7] = glyph[d[i]];
                end
            end
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_hex(input int t);
        if (!m_ctrl[0]) return AllBlank;
        if (m_ctrl[2] && m_bdiv != 0 && (((t - m_bcyc) / m_bdiv) % 2) == 1) return AllBlank;
        return (t >= m_sw) ? m_new : m_old;
    endfunction

    function automatic logic [31:0] exp_read(input logic [1:0] a, input int t);
        bit busy, ovf;
        busy = (t > m_start) && (t <= m_start + 17);
        ovf  = (t >= m_sw) ? m_novf : m_oovf;
        case (a)
            2'd0:    return {16'h0, m_value};
            2'd1:    return {28'h0, m_ctrl};
            2'd2:    return {30'h0, ovf, busy};
            default: return {8'h0, m_bdiv[23:0]};
        endcase
    endfunction

    task automatic model_reset();
        m_value = '0;
        m_ctrl  = '0;
        m_bdiv  = 0;
        m_bcyc  = 0;
        m_start = -1000;
        m_sw    = 0;
        m_old   = AllBlank;
        m_new   = AllBlank;
        m_oovf  = 1'b0;
        m_novf  = 1'b0;
    endtask

    task automatic model_start(input int c);
        if (c >= m_sw) begin
            m_old  = m_new;
            m_oovf = m_novf;
        end
        m_new   = disp_of(m_value, m_ctrl);
        m_novf  = m_ctrl[1] && (m_value > 16'd9999);
        m_sw    = c + 18;
        m_start = c;
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] d, input int c);
        case (a)
            2'd0: begin m_value = d[15:0]; model_start(c); end
            2'd1: begin m_ctrl = d[3:0] & (BlinkEn ? 4'hF : 4'hB); model_start(c); end
            2'd3: begin m_bdiv = BlinkEn ? int'(d[23:0]) : 0; m_bcyc = c + 1; end
            default: ;
        endcase
    endtask

    task automatic push(input bit is_hex, input logic [31:0] e, input string nm);
        q_cyc.push_back(cyc);
        q_hex.push_back(is_hex);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    always @(negedge clk) begin
        int          c;
        bit          h;
        logic [31:0] e, act;
        string       nm;
        while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
            c  = q_cyc.pop_front();
            h  = q_hex.pop_front();
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            act = h ? {4'h0, hex3, hex2, hex1, hex0} : bus_if.readdata;
            checks++;
            if (act !== e || c != cyc) begin
                errors++;
                $display("FAIL %s cyc=%0d due=%0d got=%h expected=%h", nm, cyc, c, act, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd0;
        bus_if.writedata  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            push(1'b1, {4'h0, exp_hex(cyc)}, "hex");
            tick();
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        push(1'b1, {4'h0, exp_hex(cyc)}, "hex");
        model_write(a, d, cyc);
        tick();
    endtask

    task automatic rd_exp(input logic [1:0] a, input logic [31:0] e, input string nm);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = a;
        bus_if.writedata  = '0;
        push(1'b0, e, nm);
        push(1'b1, {4'h0, exp_hex(cyc)}, "hex");
        tick();
    endtask

    task automatic rd(input logic [1:0] a);
        rd_exp(a, exp_read(a, cyc), $sformatf("rd%0d", a));
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        idle(n);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [3:0]  c;
        logic [15:0] v;
        reset_n = 1'b0;
        drive_idle();
        model_reset();
        tick();
        do_reset(3);

        // Post-reset register and display state
        for (int a = 0; a < 4; a++) rd_exp(2'(a), 32'h0, $sformatf("reset_rd%0d", a));
        push(1'b1, {4'h0, AllBlank}, "reset_hex");

        // Hex mode BEEF, busy window then glyphs b,E,E,F
        wr(AddrCtrl, 32'h1);
        wr(AddrValue, 32'hBEEF);
        for (int i = 0; i < 17; i++) rd(AddrStatus);
        push(1'b1, {4'h0, 7'h03, 7'h06, 7'h06, 7'h0E}, "beef_hex");
        rd_exp(AddrStatus, 32'h0, "beef_idle");

        // Decimal 42 with leading-zero blanking
        wr(AddrCtrl, 32'hB);
        wr(AddrValue, 32'd42);
        idle(17);
        push(1'b1, {4'h0, 7'h7F, 7'h7F, 7'h19, 7'h24}, "dec42_hex");
        rd_exp(AddrStatus, 32'h0, "dec42_status");

        // Decimal overflow shows dashes
        wr(AddrValue, 32'd10000);
        idle(17);
        push(1'b1, {4'h0, {4{7'h3F}}}, "ovf_hex");
        rd_exp(AddrStatus, 32'h2, "ovf_status");

        // Restart mid-conversion: 1234 must never appear
        wr(AddrCtrl, 32'h3);
        wr(AddrValue, 32'd1234);
        idle(8);
        wr(AddrValue, 32'd5678);
        idle(17);
        push(1'b1, {4'h0, 7'h12, 7'h02, 7'h78, 7'h00}, "restart_hex");
        idle(3);

`ifdef HEX_BCD_BLINK_EN
        wr(AddrBlinkDiv, 32'd4);
        wr(AddrCtrl, 32'h5);
        idle(40);
        rd_exp(AddrBlinkDiv, 32'd4, "blinkdiv_rd");
`else
        wr(AddrBlinkDiv, 32'd4);
        wr(AddrCtrl, 32'h5);
        rd_exp(AddrBlinkDiv, 32'd0, "blinkdiv_rd");
        rd_exp(AddrCtrl, 32'h1, "ctrl_blink_rd");
        idle(20);
`endif

        // Randomized register traffic
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    case ($urandom_range(0, 3))
                        0:       v = 16'($urandom_range(0, 99));
                        1:       v = 16'($urandom_range(0, 9999));
                        2:       v = 16'($urandom_range(10000, 65535));
                        default: v = 16'($urandom);
                    endcase
                    wr(AddrValue, {16'($urandom), v});
                end
                3, 4: begin
                    c = 4'($urandom_range(0, 15));
                    if ($urandom_range(0, 4) != 0) c[0] = 1'b1;
                    wr(AddrCtrl, {28'($urandom), c});
                end
                5:       wr(AddrBlinkDiv, 32'($urandom_range(0, 6)));
                6, 7:    rd(2'($urandom_range(0, 3)));
                default: idle($urandom_range(1, 22));
            endcase
        end
        idle(20);

        // Reset during a conversion discards it
        wr(AddrCtrl, 32'h1);
        wr(AddrValue, 32'h1111);
        idle(5);
        do_reset(2);
        idle(20);
        for (int a = 0; a < 4; a++) rd_exp(2'(a), 32'h0, $sformatf("midreset_rd%0d", a));
        idle(2);

        checks++;
        if (q_cyc.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", q_cyc.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_bcd_display.md
HEX_BCD_DISPLAY -- requirements
Module: hex_bcd_display

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: address  input  2  Avalon-MM word address.
REQ-004 SHALL have port: chipselect  input  1  slave select.
REQ-005 SHALL have port: write_n  input  1  active-low write strobe.
REQ-006 SHALL have port: writedata  input  32  write data.
REQ-007 SHALL have port: readdata  output  32  read data, zero-extended.
REQ-008 SHALL have ports: hex0..hex3  output  7 each  active-low segments; bit0=a ... bit6=g; hex0 = least significant digit.
REQ-009 SHALL implement registers: 0 VALUE[15:0], 1 CTRL[3:0] = {lzb, blink, mode, enable}, 2 STATUS[1:0] = {ovf, busy} (read-only), 3 BLINK_DIV[23:0].

Function
REQ-010 SHALL accept a write when chipselect=1 and write_n=0, with zero wait states.
REQ-011 SHALL drive readdata combinationally with the addressed register when chipselect=1, and with 0 otherwise; unused bits SHALL read 0.
REQ-012 SHALL start a conversion on any write to VALUE or CTRL: FSM IDLE -> SHIFT (16 cycles, double-dabble) -> LATCH (1 cycle) -> IDLE.
REQ-013 SHALL assert busy from the cycle after the write through LATCH inclusive; new digits SHALL be visible on hex0..3 at write cycle + 18.
REQ-014 SHALL abort and restart the conversion from SHIFT cycle 0 with the new register contents when VALUE or CTRL is written while busy.
REQ-015 SHALL, in hex mode (mode=0), latch VALUE nibbles [3:0]..[15:12] to hex0..hex3 at LATCH.
REQ-016 SHALL, in decimal mode (mode=1), latch the BCD digits; if VALUE > 9999, SHALL set ovf=1 and show "----" (7'b0111111 on all digits); otherwise SHALL set ovf=0.
REQ-017 SHALL, when lzb=1 in decimal mode, blank (7'h7F) leading zero digits hex3..hex1; hex0 SHALL never be blanked by lzb.
REQ-018 SHALL drive all outputs to 7'h7F whenever enable=0, independent of FSM state.
REQ-019 SHALL use a 24-bit blink counter that counts 0..BLINK_DIV-1 and toggles the blink phase on wrap; when BLINK_DIV=0, the counter and phase SHALL hold at 0.
REQ-020 SHALL blank all digits while blink=1 and phase=1.
REQ-021 SHALL clear the counter and phase on a BLINK_DIV write.
REQ-022 SHALL decode digit values A-F with standard 7-seg glyphs (A, b, C, d, E, F).

Reset
REQ-023 SHALL, on reset_n=0, asynchronously clear all registers, the counter, and the phase, set the FSM to IDLE, and drive hex0..3 to 7'h7F.
REQ-024 SHALL discard an in-progress conversion on reset mid-operation; no partial digits SHALL appear after release.

Configuration
REQ-025 SHALL, with macro HEX_BCD_BLINK_EN defined, implement REQ-019 to REQ-021.
REQ-026 SHALL, without HEX_BCD_BLINK_EN, omit the counter; BLINK_DIV and CTRL.blink SHALL read 0, ignore writes, and never blank.

Structure
REQ-027 SHALL take from package hex_bcd_pkg: the register address constants, the FSM state enum, the blank and dash segment constants, and the CTRL bit indices.
REQ-028 SHALL use sub-module hex_seg_decode (4-bit nibble to 7-bit active-low segments, combinational), instantiated four times.

Verification
REQ-029 SHALL cover: reset released, then read all registers -> all 0, hex0..3=7'h7F.
REQ-030 SHALL cover: CTRL=0x1, then VALUE=0xBEEF -> busy for 17 cycles; then hex3..0 = b,E,E,F (7'h03, 7'h06, 7'h06, 7'h0E).
REQ-031 SHALL cover: CTRL=0xB (enable, decimal, lzb), then VALUE=42 -> hex1 shows 4 (7'h19), hex0 shows 2 (7'h24), hex3 and hex2 = 7'h7F, ovf=0.
REQ-032 SHALL cover: decimal mode, then VALUE=10000 -> all digits 7'b0111111, STATUS=0b10 after completion.
REQ-033 SHALL cover: VALUE=1234 written, then VALUE=5678 at SHIFT cycle 8 -> 1234 is never displayed; 5678 appears at second write + 18.
REQ-034 SHALL cover (HEX_BCD_BLINK_EN): BLINK_DIV=4, CTRL=0x5 -> outputs alternate 4 cycles lit / 4 cycles 7'h7F; without the macro, BLINK_DIV reads 0.
